// File: rtl/edge_frame_writer_if.sv
// Stream-in / frame-buffer-write bundle for edge_frame_writer.
// The master drives the pixel stream and write-ready; the slave is the writer block.
interface edge_frame_writer_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              sof;
  logic [3:0]        pix_in;
  logic              pix_valid;
  logic              wr_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;
  logic              frame_done;
  logic              busy;
  logic              overflow;

  modport master (
    output sof, pix_in, pix_valid, wr_ready,
    input  wr_en, wr_addr, wr_data, frame_done, busy, overflow
  );

  modport slave (
    input  sof, pix_in, pix_valid, wr_ready,
    output wr_en, wr_addr, wr_data, frame_done, busy, overflow
  );
endinterface

// File: rtl/edge_frame_writer.sv
// Realigns the 5x5 edge-filter output stream to raster coordinates, masks the 2-pixel
// border and writes one nibble per pixel through a small FIFO, then self-writes the tail.
module edge_frame_writer #(
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = $clog2(IMG_W * IMG_H)
) (
  input logic                clk,
  input logic                rst_n,
  edge_frame_writer_if.slave bus
);

  localparam int unsigned OFFSET = 2 * IMG_W + 2;
  localparam int unsigned TOTAL  = IMG_W * IMG_H;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned CX_W   = $clog2(IMG_W);
  localparam int unsigned CY_W   = $clog2(IMG_H);
  localparam int unsigned FL_W   = $clog2(OFFSET + 1);

  typedef enum logic [2:0] {
    StIdle,
    StPrime,
    StStream,
    StFlush,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] in_cnt_q, in_cnt_d;
  logic [CX_W-1:0]   cx_q, cx_d;
  logic [CY_W-1:0]   cy_q, cy_d;
  logic              push_q, push_d;
  logic [3:0]        push_data_q, push_data_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic [3:0]        mem_q [FIFO_DEPTH];

  logic accept;
  logic fifo_empty;
  logic fifo_full;
  logic flush_wr;
  logic wr_en;
  logic handshake;
  logic pop;
  logic push_en;
  logic in_bounds;

  assign accept     = bus.pix_valid &&
                      (bus.sof || state_q == StPrime || state_q == StStream);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  // The push stage counts as occupancy so tail writes never overtake the last sample.
  assign flush_wr   = (state_q == StFlush) && fifo_empty && !push_q &&
                      (flush_cnt_q < FL_W'(OFFSET));
  assign wr_en      = !fifo_empty || flush_wr;
  assign handshake  = wr_en && bus.wr_ready;
  assign pop        = handshake && !fifo_empty;
  assign push_en    = push_q && (!fifo_full || pop);
  assign in_bounds  = (cx_q >= CX_W'(2)) && (cx_q <= CX_W'(IMG_W - 3)) &&
                      (cy_q >= CY_W'(2)) && (cy_q <= CY_W'(IMG_H - 3));

  always_comb begin
    state_d      = state_q;
    in_cnt_d     = in_cnt_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    push_d       = 1'b0;
    push_data_d  = push_data_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    wr_addr_d    = wr_addr_q;
    flush_cnt_d  = flush_cnt_q;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    overflow_d   = overflow_q;

    if (bus.sof) begin
      // Restart wins over everything, including a handshake or push in this cycle.
      state_d     = StPrime;
      in_cnt_d    = accept ? ADDR_W'(1) : '0;
      cx_d        = '0;
      cy_d        = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      wr_addr_d   = '0;
      flush_cnt_d = '0;
      busy_d      = 1'b1;
      overflow_d  = 1'b0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_en, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (push_q && !push_en) overflow_d = 1'b1;
      if (handshake)             wr_addr_d   = wr_addr_q + ADDR_W'(1);
      if (handshake && flush_wr) flush_cnt_d = flush_cnt_q + FL_W'(1);

      case (state_q)
        StPrime: begin
          if (accept) begin
            in_cnt_d = in_cnt_q + ADDR_W'(1);
            if (in_cnt_q == ADDR_W'(OFFSET - 1)) state_d = StStream;
          end
        end
        StStream: begin
          if (accept) begin
            in_cnt_d    = in_cnt_q + ADDR_W'(1);
            push_d      = 1'b1;
            push_data_d = in_bounds ? bus.pix_in : 4'h0;
            if (cx_q == CX_W'(IMG_W - 1)) begin
              cx_d = '0;
              cy_d = cy_q + CY_W'(1);
            end else begin
              cx_d = cx_q + CX_W'(1);
            end
            if (in_cnt_q == ADDR_W'(TOTAL - 1)) state_d = StFlush;
          end
        end
        StFlush: begin
          if (handshake && flush_wr && (flush_cnt_q == FL_W'(OFFSET - 1))) begin
            state_d      = StDone;
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      in_cnt_q     <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      push_q       <= 1'b0;
      push_data_q  <= 4'h0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wr_addr_q    <= '0;
      flush_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wr_addr_q    <= wr_addr_d;
      flush_cnt_q  <= flush_cnt_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_q;
  end

  assign bus.wr_en      = wr_en;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = fifo_empty ? 4'h0 : mem_q[rd_ptr_q];
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_edge_frame_writer.sv
// Directed bench for edge_frame_writer on an 8x6 frame (18 priming samples, 48 pixels).
module tb_edge_frame_writer;
  localparam int unsigned IMG_W  = 8;
  localparam int unsigned IMG_H  = 6;
  localparam int unsigned ADDR_W = $clog2(IMG_W * IMG_H);
  localparam int          OFFSET = 2 * IMG_W + 2;
  localparam int          TOTAL  = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  edge_frame_writer_if #(.ADDR_W(ADDR_W)) bus ();

  edge_frame_writer #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .FIFO_DEPTH(8),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_addr[$];
  int hs_data[$];
  int last_hs_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int done_busy = 0;
  int stab_err = 0;
  int sent_pix[TOTAL];
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [3:0]        prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port log: handshakes, done pulses and hold-during-stall violations.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(bus.wr_en && bus.wr_addr == prev_addr && bus.wr_data == prev_data))
        stab_err++;
      if (bus.wr_en && bus.wr_ready && !bus.sof) begin
        hs_addr.push_back(int'(bus.wr_addr));
        hs_data.push_back(int'(bus.wr_data));
        last_hs_cyc = cyc;
      end
      if (bus.frame_done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = int'(bus.busy);
      end
      prev_stall = bus.wr_en && !bus.wr_ready && !bus.sof;
      prev_addr  = bus.wr_addr;
      prev_data  = bus.wr_data;
    end
  end

  function automatic int exp_data(int a);
    int cx;
    int cy;
    if (a >= TOTAL - OFFSET) return 0;
    cx = a % IMG_W;
    cy = a / IMG_W;
    if (cx >= 2 && cx <= IMG_W - 3 && cy >= 2 && cy <= IMG_H - 3) return sent_pix[a + OFFSET];
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    hs_addr.delete();
    hs_data.delete();
    done_cnt = 0;
    stab_err = 0;
  endtask

  task automatic test_reset();
    bus.sof = 1'b0; bus.pix_valid = 1'b0; bus.pix_in = 4'h0; bus.wr_ready = 1'b0;
    #3;
    n_cmp++;
    if ({bus.wr_en, bus.frame_done, bus.busy, bus.overflow} !== 4'b0 || bus.wr_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: en=%b addr=%0d done=%b busy=%b ovf=%b, want all 0",
               bus.wr_en, bus.wr_addr, bus.frame_done, bus.busy, bus.overflow);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    bus.sof = 1'b1; bus.wr_ready = 1'b1;
    step();
    bus.sof = 1'b0;
    for (int i = 0; i < 24; i++) begin
      bus.pix_valid = 1'b1; bus.pix_in = 4'h5;
      step();
    end
    bus.pix_valid = 1'b0;
    n_cmp++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(4) || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_preactive: en=%b addr=%0d busy=%b, want 1 4 1",
               bus.wr_en, bus.wr_addr, bus.busy);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.wr_en, bus.frame_done, bus.busy, bus.overflow} !== 4'b0 ||
        bus.wr_addr !== '0 || bus.wr_data !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_async: en=%b addr=%0d data=%h done=%b busy=%b ovf=%b, want all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done, bus.busy, bus.overflow);
    end
    step();
    rst_n = 1'b1;
    step();
    clear_log();
    for (int i = 0; i < 20; i++) begin
      bus.pix_valid = 1'b1; bus.pix_in = 4'hF;
      step();
    end
    bus.pix_valid = 1'b0;
    step(); step();
    n_cmp++;
    if (hs_addr.size() !== 0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_ignores: writes=%0d en=%b busy=%b, want 0 0 0",
               hs_addr.size(), bus.wr_en, bus.busy);
    end
  endtask

  task automatic test_nominal();
    clear_log();
    bus.sof = 1'b1; bus.wr_ready = 1'b1;
    step();
    bus.sof = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL nominal_busy_rise: got %b want 1", bus.busy);
    end
    for (int i = 0; i < TOTAL; i++) begin
      sent_pix[i] = 15;
      bus.pix_valid = 1'b1; bus.pix_in = 4'hF;
      step();
    end
    bus.pix_valid = 1'b0;
    for (int i = 0; i < 200 && done_cnt == 0; i++) step();
    step(); step(); step();
    n_cmp++;
    if (hs_addr.size() !== TOTAL) begin
      n_fail++;
      $display("FAIL nominal_count: got %0d writes want %0d", hs_addr.size(), TOTAL);
    end
    for (int i = 0; i < hs_addr.size() && i < TOTAL; i++) begin
      n_cmp++;
      if (hs_addr[i] !== i || hs_data[i] !== exp_data(i)) begin
        n_fail++;
        $display("FAIL nominal_write[%0d]: got addr=%0d data=%0h want addr=%0d data=%0h",
                 i, hs_addr[i], hs_data[i], i, exp_data(i));
      end
    end
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== last_hs_cyc + 1 || done_busy !== 0) begin
      n_fail++;
      $display("FAIL nominal_done: pulses=%0d at=%0d busy=%0d, want 1 at %0d busy 0",
               done_cnt, done_cyc, done_busy, last_hs_cyc + 1);
    end
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL nominal_end: ovf=%b busy=%b en=%b want 0 0 0",
               bus.overflow, bus.busy, bus.wr_en);
    end
  endtask

  task automatic test_overflow();
    clear_log();
    bus.sof = 1'b1; bus.wr_ready = 1'b0;
    step();
    bus.sof = 1'b0;
    for (int i = 0; i < 27; i++) begin
      bus.pix_valid = 1'b1; bus.pix_in = 4'h9;
      step();
    end
    bus.pix_valid = 1'b0;
    n_cmp++;
    if (bus.overflow !== 1'b0 || bus.wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_full_no_drop: ovf=%b en=%b want 0 1", bus.overflow, bus.wr_en);
    end
    step();
    n_cmp++;
    if (bus.overflow !== 1'b1 || bus.wr_addr !== '0) begin
      n_fail++;
      $display("FAIL overflow_set: ovf=%b addr=%0d want 1 0", bus.overflow, bus.wr_addr);
    end
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    n_cmp++;
    if (hs_addr.size() !== 8) begin
      n_fail++;
      $display("FAIL overflow_count: got %0d writes want 8", hs_addr.size());
    end
    for (int i = 0; i < hs_addr.size() && i < 8; i++) begin
      n_cmp++;
      if (hs_addr[i] !== i || hs_data[i] !== 0) begin
        n_fail++;
        $display("FAIL overflow_write[%0d]: got addr=%0d data=%0h want addr=%0d data=0",
                 i, hs_addr[i], hs_data[i], i);
      end
    end
    n_cmp++;
    if (bus.overflow !== 1'b1 || bus.wr_addr !== ADDR_W'(8) || bus.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_sticky: ovf=%b addr=%0d en=%b want 1 8 0",
               bus.overflow, bus.wr_addr, bus.wr_en);
    end
  endtask

  task automatic test_mid_frame_sof();
    clear_log();
    bus.sof = 1'b1; bus.wr_ready = 1'b1;
    step();
    bus.sof = 1'b0;
    n_cmp++;
    if (bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midsof_ovf_clear: got %b want 0", bus.overflow);
    end
    for (int i = 0; i < 30; i++) begin
      bus.pix_valid = 1'b1; bus.pix_in = 4'h7;
      step();
    end
    bus.pix_valid = 1'b0;
    n_cmp++;
    if (bus.wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL midsof_pending: en=%b want 1", bus.wr_en);
    end
    for (int i = 0; i < TOTAL; i++) sent_pix[i] = (i % 15) + 1;
    bus.sof = 1'b1; bus.pix_valid = 1'b1; bus.pix_in = 4'(sent_pix[0]);
    step();
    bus.sof = 1'b0;
    n_cmp++;
    if (bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midsof_abort: en=%b addr=%0d busy=%b want 0 0 1",
               bus.wr_en, bus.wr_addr, bus.busy);
    end
    hs_addr.delete();
    hs_data.delete();
    for (int i = 1; i < TOTAL; i++) begin
      bus.pix_valid = 1'b1; bus.pix_in = 4'(sent_pix[i]);
      step();
    end
    bus.pix_valid = 1'b0;
    for (int i = 0; i < 200 && done_cnt == 0; i++) step();
    step(); step();
    n_cmp++;
    if (hs_addr.size() !== TOTAL) begin
      n_fail++;
      $display("FAIL midsof_count: got %0d writes want %0d", hs_addr.size(), TOTAL);
    end
    for (int i = 0; i < hs_addr.size() && i < TOTAL; i++) begin
      n_cmp++;
      if (hs_addr[i] !== i || hs_data[i] !== exp_data(i)) begin
        n_fail++;
        $display("FAIL midsof_write[%0d]: got addr=%0d data=%0h want addr=%0d data=%0h",
                 i, hs_addr[i], hs_data[i], i, exp_data(i));
      end
    end
    n_cmp++;
    if (done_cnt !== 1 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL midsof_done: pulses=%0d ovf=%b want 1 0", done_cnt, bus.overflow);
    end
  endtask

  task automatic test_backpressure();
    int c;
    clear_log();
    for (int i = 0; i < TOTAL; i++) sent_pix[i] = 15 - (i % 13);
    bus.sof = 1'b1; bus.wr_ready = 1'b1;
    step();
    bus.sof = 1'b0;
    c = 0;
    for (int i = 0; i < TOTAL * 3; i++) begin
      bus.pix_valid = (i % 3 == 0);
      bus.pix_in    = 4'(sent_pix[i / 3]);
      bus.wr_ready  = (i % 2 == 1);
      step();
      c++;
    end
    bus.pix_valid = 1'b0;
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      bus.wr_ready = (c % 2 == 1);
      step();
      c++;
    end
    bus.wr_ready = 1'b1;
    step(); step();
    n_cmp++;
    if (hs_addr.size() !== TOTAL) begin
      n_fail++;
      $display("FAIL bp_count: got %0d writes want %0d", hs_addr.size(), TOTAL);
    end
    for (int i = 0; i < hs_addr.size() && i < TOTAL; i++) begin
      n_cmp++;
      if (hs_addr[i] !== i || hs_data[i] !== exp_data(i)) begin
        n_fail++;
        $display("FAIL bp_write[%0d]: got addr=%0d data=%0h want addr=%0d data=%0h",
                 i, hs_addr[i], hs_data[i], i, exp_data(i));
      end
    end
    n_cmp++;
    if (stab_err !== 0 || bus.overflow !== 1'b0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL bp_stable: hold_violations=%0d ovf=%b pulses=%0d want 0 0 1",
               stab_err, bus.overflow, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overflow();
    test_mid_frame_sof();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
